// File: rtl/alu_sched.sv
// -----------------------------------------------------------------------------
// alu_sched
// Two-requester front end for a shared combinational ALU. It grants one
// requester, holds that requester's operands on the ALU for one cycle, and
// captures the result. The result is then held until the consumer accepts it.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid[1:0]         per-requester operation valid
//   req_ready[1:0]         per-requester accept strobe (one-hot or zero)
//   req_op[7:0]            4-bit opcode per requester ([3:0] req0, [7:4] req1)
//   req_a[15:0], req_b     8-bit operands per requester ([7:0] req0, [15:8] req1)
//   req_cin[1:0]           carry-in per requester
//   alu_s_af, alu_a, alu_b, alu_cin   operands driven to the ALU
//   alu_sel_a, alu_sel_b   operand-source selects, tied to direct operands
//   alu_out, alu_flags     ALU result and flags {OddParity, Positive, Cout, Zero}
//   rsp_valid/rsp_ready    response handshake
//   rsp_id, rsp_data, rsp_flags   issuing requester, captured result and flags
//   busy                   high whenever an operation is in flight
// -----------------------------------------------------------------------------
module alu_sched #(
    parameter int RR_ENABLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [7:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [1:0]  req_cin,
    output logic [3:0]  alu_s_af,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    output logic        alu_sel_a,
    output logic        alu_sel_b,
    input  logic [7:0]  alu_out,
    input  logic [3:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_data,
    output logic [3:0]  rsp_flags,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;
    logic        grant_id;
    logic        grant_any;
    logic [3:0]  op_reg;
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic        cin_reg;
    logic        id_reg;
    logic [7:0]  data_reg;
    logic [3:0]  flags_reg;
    logic        rsp_valid_reg;
    logic        busy_reg;

    assign grant_any = |req_valid;

    generate
        if (RR_ENABLE != 0) begin : g_rr
            // On a tie the requester that did not win last time gets the slot.
            always_comb begin
                grant_id = 1'b0;
                case (req_valid)
                    2'b01:   grant_id = 1'b0;
                    2'b10:   grant_id = 1'b1;
                    2'b11:   grant_id = ~last_grant;
                    default: grant_id = 1'b0;
                endcase
            end
        end else begin : g_fixed
            always_comb begin
                grant_id = ~req_valid[0];
            end
        end
    endgenerate

    // Accept strobe is combinational so the requester sees it in the same
    // cycle its operands are sampled; it is forced low while reset is held.
    assign req_ready = (rst_n && (state == IDLE) && grant_any)
                       ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            op_reg        <= 4'h0;
            a_reg         <= 8'h00;
            b_reg         <= 8'h00;
            cin_reg       <= 1'b0;
            id_reg        <= 1'b0;
            data_reg      <= 8'h00;
            flags_reg     <= 4'h0;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_reg     <= grant_id ? req_op[7:4]  : req_op[3:0];
                        a_reg      <= grant_id ? req_a[15:8]  : req_a[7:0];
                        b_reg      <= grant_id ? req_b[15:8]  : req_b[7:0];
                        cin_reg    <= grant_id ? req_cin[1]   : req_cin[0];
                        id_reg     <= grant_id;
                        last_grant <= grant_id;
                        busy_reg   <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    data_reg      <= alu_out;
                    flags_reg     <= alu_flags;
                    rsp_valid_reg <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    // The operand registers only load on a grant, so the ALU inputs stay
    // put for the whole EXEC and RESP period.
    assign alu_s_af  = op_reg;
    assign alu_a     = a_reg;
    assign alu_b     = b_reg;
    assign alu_cin   = cin_reg;
    assign alu_sel_a = 1'b0;
    assign alu_sel_b = 1'b0;

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = id_reg;
    assign rsp_data  = data_reg;
    assign rsp_flags = flags_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_alu_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_sched
// Bench for alu_sched with a behavioural ALU attached. A cycle model of the
// scheduler is checked against the DUT on every falling edge; directed
// vectors add literal expectations for the arbitration order, latency,
// back-pressure and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_alu_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [1:0]  req_cin;
    logic [3:0]  alu_s_af;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic        alu_sel_a;
    logic        alu_sel_b;
    logic [7:0]  alu_out;
    logic [3:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [7:0]  rsp_data;
    logic [3:0]  rsp_flags;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    alu_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .alu_s_af  (alu_s_af),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_sel_a (alu_sel_a),
        .alu_sel_b (alu_sel_b),
        .alu_out   (alu_out),
        .alu_flags (alu_flags),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Team ALU behaviour: returns {OddParity, Positive, Cout, Zero, result}.
    function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
        logic [8:0] w;
        logic [7:0] r;
        logic       co;
        w  = 9'h000;
        co = 1'b0;
        case (op)
            4'h8: begin
                w  = {1'b0, a} + {1'b0, b} + {8'h00, cin};
                r  = w[7:0];
                co = w[8];
            end
            4'h9: begin
                w  = {1'b0, b} - {1'b0, a} - {8'h00, cin};
                r  = w[7:0];
                co = w[8];
            end
            4'hC:    r = a & b;
            default: r = a ^ (b + {7'h00, cin}) ^ {op, op};
        endcase
        return {^r, ~r[7], co, (r == 8'h00), r};
    endfunction

    assign {alu_flags, alu_out} = alu_fn(alu_s_af, alu_a, alu_b, alu_cin);

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    int          m_age = 0;      // cycles since accept; 0 = nothing in flight
    logic        m_last = 1'b1;
    logic        m_id = 1'b0;
    logic [3:0]  m_op = 4'h0;
    logic [7:0]  m_a = 8'h00;
    logic [7:0]  m_b = 8'h00;
    logic        m_cin = 1'b0;
    logic [11:0] m_exp = 12'h000;
    int          grants_q[$];
    int          acc_cyc = 0;
    int          first_gap = -1;

    always @(negedge clk) begin
        logic g;
        if (!rst_n) begin
            m_age = 0; m_last = 1'b1; m_op = 4'h0; m_a = 8'h00; m_b = 8'h00; m_cin = 1'b0;
            chk("rst_req_ready", req_ready, 2'b00);
            chk("rst_busy", busy, 1'b0);
            chk("rst_rsp_valid", rsp_valid, 1'b0);
            chk("rst_rsp_data", rsp_data, 8'h00);
            chk("rst_rsp_flags", rsp_flags, 4'h0);
            chk("rst_rsp_id", rsp_id, 1'b0);
            chk("rst_alu_ops", {alu_s_af, alu_a, alu_b, alu_cin}, 21'h0);
        end else begin
            chk("alu_operands", {alu_s_af, alu_a, alu_b, alu_cin}, {m_op, m_a, m_b, m_cin});
            chk("alu_sel", {alu_sel_a, alu_sel_b}, 2'b00);
            if (m_age == 0) begin
                if (req_valid == 2'b11) g = ~m_last;
                else                    g = (req_valid == 2'b10);
                chk("idle_busy", busy, 1'b0);
                chk("idle_rsp_valid", rsp_valid, 1'b0);
                chk("idle_req_ready", req_ready,
                    (req_valid == 2'b00) ? 2'b00 : (g ? 2'b10 : 2'b01));
                if (req_valid != 2'b00) begin
                    m_id  = g;
                    m_op  = g ? req_op[7:4] : req_op[3:0];
                    m_a   = g ? req_a[15:8] : req_a[7:0];
                    m_b   = g ? req_b[15:8] : req_b[7:0];
                    m_cin = req_cin[g];
                    m_exp = alu_fn(m_op, m_a, m_b, m_cin);
                    m_last = g;
                    grants_q.push_back(int'(g));
                    acc_cyc = cyc;
                    m_age = 1;
                end
            end else if (m_age == 1) begin
                chk("exec_busy", busy, 1'b1);
                chk("exec_rsp_valid", rsp_valid, 1'b0);
                chk("exec_req_ready", req_ready, 2'b00);
                m_age = 2;
            end else begin
                chk("resp_busy", busy, 1'b1);
                chk("resp_rsp_valid", rsp_valid, 1'b1);
                chk("resp_req_ready", req_ready, 2'b00);
                chk("resp_id", rsp_id, m_id);
                chk("resp_data", rsp_data, m_exp[7:0]);
                chk("resp_flags", rsp_flags, m_exp[11:8]);
                if (m_age == 2 && first_gap < 0) first_gap = cyc - acc_cyc;
                if (rsp_ready) begin
                    $display("txn id=%0d op=%h a=%h b=%h cin=%0d -> data=%h flags=%b",
                             m_id, m_op, m_a, m_b, m_cin, rsp_data, rsp_flags);
                    m_age = 0;
                end else begin
                    m_age = m_age + 1;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        int         id;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] d;
        logic [3:0] f;
    } vec_t;

    vec_t vecs[6] = '{
        '{0, 4'h8, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1000},
        '{1, 4'h9, 8'h05, 8'h03, 1'b0, 8'hFE, 4'b1010},
        '{0, 4'hC, 8'hF0, 8'h0F, 1'b0, 8'h00, 4'b0101},
        '{1, 4'h8, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0111},
        '{0, 4'h8, 8'h10, 8'h20, 1'b1, 8'h31, 4'b1100},
        '{1, 4'h3, 8'h0F, 8'h01, 1'b0, 8'h3D, 4'b1100}
    };

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while ((busy || rsp_valid) && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", (k < 30), 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int id, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic cin);
        req_op[id*4 +: 4] = op;
        req_a[id*8 +: 8]  = a;
        req_b[id*8 +: 8]  = b;
        req_cin[id]       = cin;
    endtask

    // Issues one operation and checks the literal response.
    task automatic issue(input vec_t v);
        bit acc;
        bit got;
        wait_idle();
        set_req(v.id, v.op, v.a, v.b, v.cin);
        req_valid[v.id] = 1'b1;
        acc = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            if (req_ready[v.id]) acc = 1;
        end
        chk("vec_accepted", acc, 1'b1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        chk("vec_rsp_seen", got, 1'b1);
        chk("vec_data", rsp_data, v.d);
        chk("vec_flags", rsp_flags, v.f);
        chk("vec_id", rsp_id, v.id);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] s_d;
        logic [3:0] s_f;
        logic       s_id;
        bit         got;

        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_op    = 8'h98;
        req_a     = 16'h0511;
        req_b     = 16'h0322;
        req_cin   = 2'b00;
        rsp_ready = 1'b1;

        // Reset held with both requesters valid: nothing may be granted.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_ready", req_ready, 2'b00);
        chk("rst_hold_busy", busy, 1'b0);
        rst_n = 1'b1;

        // Both valid from reset: grants alternate, first tie goes to 0.
        repeat (12) @(posedge clk);
        #1;
        req_valid = 2'b00;
        chk("rr_grant_count_ge4", (grants_q.size() >= 4), 1'b1);
        for (int i = 0; i < 4 && i < grants_q.size(); i++)
            chk("rr_grant_order", grants_q[i], i % 2);
        chk("first_accept_to_rsp_gap", first_gap, 2);

        // Directed operation vectors.
        foreach (vecs[i]) issue(vecs[i]);

        // Back-pressure: response held for five cycles with both requests pending.
        wait_idle();
        rsp_ready = 1'b0;
        set_req(0, 4'h8, 8'h22, 8'h11, 1'b0);
        set_req(1, 4'h9, 8'h01, 8'h10, 1'b0);
        req_valid = 2'b11;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        chk("stall_rsp_seen", got, 1'b1);
        s_d = rsp_data; s_f = rsp_flags; s_id = rsp_id;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_data", rsp_data, s_d);
            chk("stall_flags", rsp_flags, s_f);
            chk("stall_id", rsp_id, s_id);
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_req_ready", req_ready, 2'b00);
            chk("stall_busy", busy, 1'b1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_idle_busy", busy, 1'b0);
        chk("release_grant", (req_ready != 2'b00), 1'b1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_idle();

        // Asynchronous reset in EXEC after a requester-0 grant.
        set_req(0, 4'h8, 8'h40, 8'h40, 1'b1);
        req_valid = 2'b01;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1;
        end
        chk("rst_test_accept", got, 1'b1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("rst_test_in_exec", busy, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 1'b0);
        chk("async_rsp_valid", rsp_valid, 1'b0);
        chk("async_req_ready", req_ready, 2'b00);
        chk("async_rsp", {rsp_id, rsp_data, rsp_flags}, 13'h0);
        chk("async_alu", {alu_s_af, alu_a, alu_b, alu_cin}, 21'h0);
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_tie_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
